// File: rtl/mole_hit_detector.sv
// Whack-a-mole button front end: synchronizes and debounces five mole buttons,
// classifies each debounced press as a hit or miss, and keeps saturating tallies.
module mole_hit_detector #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCORE_WIDTH     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             moleButton,
  input  logic [4:0]             moleLED,
  input  logic                   gameActive,
  input  logic                   clearScore,
  output logic                   hitPulse,
  output logic [4:0]             hitMask,
  output logic                   missPulse,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] missCount
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW1 = SCORE_WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 5; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [2:0] n);
    logic [SCORE_WIDTH:0] sum;
    sum = {1'b0, a} + SW1'(n);
    return sum[SCORE_WIDTH] ? {SCORE_WIDTH{1'b1}} : sum[SCORE_WIDTH-1:0];
  endfunction

  logic [4:0]    sync1_r;
  logic [4:0]    sync2_r;
  logic [4:0]    deb_r;
  logic [4:0]    deb_d_r;
  logic [CW-1:0] cnt_r [5];

  logic [4:0] press_s;
  logic [4:0] hit_set_s;
  logic [4:0] miss_set_s;

  // Synchronize raw buttons and accept a level only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'b00000;
      sync2_r <= 5'b00000;
      deb_r   <= 5'b00000;
      deb_d_r <= 5'b00000;
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= moleButton;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          cnt_r[i] <= '0;
          deb_r[i] <= ~deb_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Press = debounced rising edge, split by which moles are lit right now
  always_comb begin
    press_s    = deb_r & ~deb_d_r;
    hit_set_s  = press_s & moleLED;
    miss_set_s = press_s & ~moleLED;
  end

  // Registered strobes and saturating tallies; clear beats a coincident increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hitPulse  <= 1'b0;
      hitMask   <= 5'b00000;
      missPulse <= 1'b0;
      score     <= '0;
      missCount <= '0;
    end else begin
      if (gameActive) begin
        hitPulse  <= |hit_set_s;
        hitMask   <= hit_set_s;
        missPulse <= |miss_set_s;
      end else begin
        hitPulse  <= 1'b0;
        hitMask   <= 5'b00000;
        missPulse <= 1'b0;
      end
      if (clearScore) begin
        score     <= '0;
        missCount <= '0;
      end else if (gameActive) begin
        score     <= sat_add(score, popcount5(hit_set_s));
        missCount <= sat_add(missCount, popcount5(miss_set_s));
      end else begin
        score     <= score;
        missCount <= missCount;
      end
    end
  end

endmodule

// File: tb/tb_mole_hit_detector.sv
// Bench for mole_hit_detector: directed scenarios plus random traffic, all
// checked against a sample-window reference model of the debounce rule.
module tb_mole_hit_detector;
  localparam int D   = 4;
  localparam int SW  = 8;
  localparam int SAT = (1 << SW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    moleButton;
  logic [4:0]    moleLED;
  logic          gameActive;
  logic          clearScore;
  logic          hitPulse;
  logic [4:0]    hitMask;
  logic          missPulse;
  logic [SW-1:0] score;
  logic [SW-1:0] missCount;

  always #5 clock = ~clock;

  mole_hit_detector #(.DEBOUNCE_CYCLES(D), .SCORE_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .moleButton(moleButton), .moleLED(moleLED),
    .gameActive(gameActive), .clearScore(clearScore), .hitPulse(hitPulse),
    .hitMask(hitMask), .missPulse(missPulse), .score(score), .missCount(missCount)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: a level is accepted once the last D synchronized samples
  // (raw samples delayed two edges) all disagree with the accepted level.
  logic [4:0] hist [0:D+1];
  logic [4:0] m_deb, m_pend, m_mask;
  logic       m_hit, m_miss;
  int         m_score, m_miss_cnt;

  task automatic model_reset();
    for (int i = 0; i < D + 2; i++) hist[i] = 5'b00000;
    m_deb = 5'b00000; m_pend = 5'b00000; m_mask = 5'b00000;
    m_hit = 1'b0; m_miss = 1'b0; m_score = 0; m_miss_cnt = 0;
  endtask

  task automatic model_step();
    logic [4:0] h, ms, nd;
    bit flip;
    if (reset) begin
      model_reset();
    end else begin
      h  = m_pend & moleLED;
      ms = m_pend & ~moleLED;
      m_hit  = gameActive && (h != 5'b00000);
      m_miss = gameActive && (ms != 5'b00000);
      m_mask = gameActive ? h : 5'b00000;
      if (clearScore) begin
        m_score = 0; m_miss_cnt = 0;
      end else if (gameActive) begin
        m_score    = (m_score + $countones(h) > SAT) ? SAT : m_score + $countones(h);
        m_miss_cnt = (m_miss_cnt + $countones(ms) > SAT) ? SAT : m_miss_cnt + $countones(ms);
      end
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = moleButton;
      nd = m_deb;
      for (int b = 0; b < 5; b++) begin
        flip = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (hist[k][b] == m_deb[b]) flip = 1'b0;
        if (flip) nd[b] = ~m_deb[b];
      end
      m_pend = nd & ~m_deb;
      m_deb  = nd;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("hitPulse", {31'd0, hitPulse}, {31'd0, m_hit});
    check("hitMask", {27'd0, hitMask}, {27'd0, m_mask});
    check("missPulse", {31'd0, missPulse}, {31'd0, m_miss});
    check("score", {24'd0, score}, m_score);
    check("missCount", {24'd0, missCount}, m_miss_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int first_hit, hits, misses, bounce_ev;
  logic [4:0] mask_seen;
  logic       miss_at_hit;

  // Run n edges, recording when the first hitPulse shows up and totals of strobes
  task automatic watch(input int n);
    first_hit = 0; hits = 0; misses = 0; mask_seen = 5'b00000; miss_at_hit = 1'b0;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (hitPulse) begin
        hits++;
        if (first_hit == 0) begin
          first_hit = e; mask_seen = hitMask; miss_at_hit = missPulse;
        end
      end
      if (missPulse) misses++;
    end
  endtask

  initial begin
    reset = 1'b1; moleButton = 5'b00000; moleLED = 5'b00000;
    gameActive = 1'b0; clearScore = 1'b0;
    model_reset();
    #1;
    check_all();
    ticks(3);
    check("reset_score", {24'd0, score}, 32'd0);

    // Clean hit on mole 2
    @(posedge clock); #1;
    reset = 1'b0; gameActive = 1'b1; moleLED = 5'b00100; moleButton = 5'b00100;
    watch(12);
    check("hit_latency", first_hit, 32'd7);
    check("hit_count", hits, 32'd1);
    check("hit_mask", {27'd0, mask_seen}, 32'h04);
    check("hit_nomiss", misses, 32'd0);
    check("hit_score", {24'd0, score}, 32'd1);
    moleButton = 5'b00000; ticks(8);

    // Bounce rejection on unlit mole 0
    moleLED = 5'b00000; bounce_ev = 0;
    for (int t = 0; t < 10; t++) begin
      moleButton[0] = ~moleButton[0];
      for (int c = 0; c < 2; c++) begin
        tick();
        if (hitPulse || missPulse) bounce_ev++;
      end
    end
    check("bounce_quiet", bounce_ev, 32'd0);
    moleButton[0] = 1'b1;
    watch(12);
    check("bounce_misses", misses, 32'd1);
    check("bounce_missCount", {24'd0, missCount}, 32'd1);
    moleButton = 5'b00000; ticks(8);

    // Simultaneous presses on buttons 0, 1 and 4
    moleLED = 5'b10001; moleButton = 5'b10011;
    watch(12);
    check("simul_hits", hits, 32'd1);
    check("simul_mask", {27'd0, mask_seen}, 32'h11);
    check("simul_miss", {31'd0, miss_at_hit}, 32'd1);
    check("simul_score", {24'd0, score}, 32'd3);
    check("simul_missCount", {24'd0, missCount}, 32'd2);
    moleButton = 5'b00000; ticks(8);

    // Inactive round: lit-mole press is ignored
    gameActive = 1'b0; moleLED = 5'b00100; moleButton = 5'b00100;
    watch(12);
    check("inactive_pulses", hits + misses, 32'd0);
    check("inactive_score", {24'd0, score}, 32'd3);
    moleButton = 5'b00000; ticks(8);

    // Reset mid-debounce with the button held through release
    gameActive = 1'b1; moleLED = 5'b00001; moleButton = 5'b00001;
    ticks(4);
    reset = 1'b1; #1;
    model_reset();
    check_all();
    ticks(2);
    reset = 1'b0;
    watch(12);
    check("rst_latency", first_hit, 32'd7);
    check("rst_hits", hits, 32'd1);
    check("rst_score", {24'd0, score}, 32'd1);
    moleButton = 5'b00000; ticks(8);

    // Saturation with five hits per press
    moleLED = 5'b11111;
    for (int r = 0; r < 52; r++) begin
      moleButton = 5'b11111; ticks(8);
      moleButton = 5'b00000; ticks(8);
    end
    check("sat_score", {24'd0, score}, 32'd255);
    moleButton = 5'b00001; ticks(8);
    check("sat_hold", {24'd0, score}, 32'd255);
    moleButton = 5'b00000; ticks(8);

    // Clear coincident with a hit
    moleButton = 5'b00010; ticks(6);
    clearScore = 1'b1; tick();
    check("clr_pulse", {31'd0, hitPulse}, 32'd1);
    check("clr_score", {24'd0, score}, 32'd0);
    clearScore = 1'b0; ticks(2);
    moleButton = 5'b00000; ticks(8);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) moleButton = 5'($urandom_range(0, 31));
      moleLED    = 5'($urandom_range(0, 31));
      gameActive = ($urandom_range(0, 7) != 0);
      clearScore = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mole_hit_detector.md
MOLE_HIT_DETECTOR -- requirements
Module: mole_hit_detector

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the stable-input cycles needed to accept a button level change (10 ms at 100 MHz); legal minimum is 1.
REQ-002 The block SHALL have parameter SCORE_WIDTH, default 8, giving the width of the score and missCount counters.
REQ-003 The block SHALL have port clock, input, 1 bit: the 100 MHz system clock, which is the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port moleButton, input, 5 bits: raw mole push-buttons, asynchronous to clock and bouncing.
REQ-006 The block SHALL have port moleLED, input, 5 bits: the currently lit moles, synchronous to clock.
REQ-007 The block SHALL have port gameActive, input, 1 bit: high while a round is running; presses are scored only while it is high.
REQ-008 The block SHALL have port clearScore, input, 1 bit: a synchronous one-cycle request to zero both counters.
REQ-009 The block SHALL have port hitPulse, output, 1 bit: a one-cycle strobe for at least one press on a lit mole.
REQ-010 The block SHALL have port hitMask, output, 5 bits: the buttons that hit; valid only while hitPulse is high, zero otherwise.
REQ-011 The block SHALL have port missPulse, output, 1 bit: a one-cycle strobe for at least one press on an unlit mole.
REQ-012 The block SHALL have port score, output, SCORE_WIDTH bits: the saturating hit count.
REQ-013 The block SHALL have port missCount, output, SCORE_WIDTH bits: the saturating miss count.

Function
REQ-014 Each moleButton bit SHALL pass through its own 2-flop synchronizer before any other use.
REQ-015 Each bit SHALL have a debounced state and a counter of width clog2(DEBOUNCE_CYCLES+1).
- The counter clears on any cycle the synchronized input equals the debounced state, and increments otherwise.
- The debounced state toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-016 A press event SHALL be a 0->1 transition of a debounced state. A release (1->0) SHALL produce no event.
REQ-017 For the press vector P of one cycle, the block SHALL compute hitSet = P & moleLED and missSet = P & ~moleLED, sampling moleLED in the same cycle the debounced state toggles.
REQ-018 All outputs SHALL be registered.
- hitPulse = |hitSet, hitMask = hitSet, missPulse = |missSet, one cycle after the debounced toggle.
- Total latency from a stable raw edge to a pulse SHALL be DEBOUNCE_CYCLES+3 clock edges.
REQ-019 Simultaneous presses in one cycle SHALL all be evaluated.
- hitPulse and missPulse may assert in the same cycle.
- score increases by popcount(hitSet); missCount increases by popcount(missSet).
REQ-020 Both counters SHALL saturate at 2^SCORE_WIDTH-1 and never wrap.
REQ-021 While gameActive is low, the block SHALL keep debouncing, but presses SHALL produce no pulses and both counters SHALL hold.
REQ-022 clearScore SHALL zero both counters at the next edge and SHALL take priority over a coincident increment, so the counter reads 0 rather than 1. Pulses in that cycle SHALL still be issued.
REQ-023 A button held through a press SHALL generate exactly one event; re-pressing SHALL require a debounced release first.

Reset
REQ-024 While reset is high, all synchronizer flops, debounced states, debounce counters, hitPulse, hitMask, missPulse, score and missCount SHALL be 0, independent of clock.
REQ-025 Reset asserted mid-debounce or mid-pulse SHALL abort the operation immediately, with no pulse after release.
REQ-026 A button already held when reset deasserts SHALL be treated as a new press.
- Its debounced state leaves reset at 0 and becomes 1 after DEBOUNCE_CYCLES+2 edges.
- That press is scored normally if gameActive is high.

Verification (DEBOUNCE_CYCLES=4, SCORE_WIDTH=8)
REQ-027 Clean hit: gameActive=1, moleLED=00100; raise moleButton[2] and hold -> hitPulse=1 for one cycle exactly 7 edges later, hitMask=00100, score 0->1, missPulse stays 0.
REQ-028 Bounce rejection: toggle moleButton[0] every 2 cycles for 20 cycles, then hold it high -> exactly one missPulse (moleLED=0), missCount=1, no events during the toggling.
REQ-029 Simultaneous: moleLED=10001; press buttons 0, 1 and 4 on the same edge -> in one cycle hitPulse=1, hitMask=10001, missPulse=1; then score=2, missCount=1.
REQ-030 Saturation and clear: preload score to 255 via hits, then one more hit -> score stays 255. Assert clearScore in the same cycle as a hit -> score=0 and hitPulse=1.
REQ-031 Inactive and reset: with gameActive=0, press a lit mole -> no pulses, counters unchanged. Assert reset mid-debounce, then release with the button still held -> counters 0, and one event follows 6 edges after release.
